// File: rtl/master_port.sv
`default_nettype none
// ============================================================================
//  Module   : master_port
//  Purpose  : Master-side serial bus port. Accepts one parallel read/write
//             request, raises read_en/write_en, waits for slave_ready, then
//             shifts address, burst and (for writes) data out LSB-first. For
//             reads it deserialises the slave's data stream LSB-first.
//
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             req_valid/req_ready     - request handshake (local master side)
//             req_write, req_addr,
//             req_wdata, req_burst    - request fields, sampled at acceptance
//             rd_valid, rd_data       - read result (pulse / held value)
//             done, err               - end-of-transaction / timeout pulses
//             read_en, write_en       - transaction direction toward slave
//             master_valid            - tx_address/tx_burst/tx_data bit valid
//             master_ready            - port is sampling read data
//             tx_address, tx_burst,
//             tx_data                 - serial outputs
//             slave_ready, slave_valid,
//             rx_data                 - serial inputs from slave
//
//  Options  : MASTER_PORT_TIMEOUT_EN  - when defined, TIMEOUT consecutive
//             wait cycles in REQ or RDATA abort the transaction with an err
//             pulse. When undefined the port waits indefinitely, err = 0.
//
//  Revision : 1.0 - initial release
// ============================================================================
module master_port #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int BURST_WIDTH = 12,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    input  logic [BURST_WIDTH-1:0] req_burst,
    output logic                   rd_valid,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   done,
    output logic                   err,
    output logic                   read_en,
    output logic                   write_en,
    output logic                   master_valid,
    output logic                   master_ready,
    output logic                   tx_address,
    output logic                   tx_burst,
    output logic                   tx_data,
    input  logic                   slave_ready,
    input  logic                   slave_valid,
    input  logic                   rx_data
);

    localparam int c_MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_CNT_W = $clog2(c_MAX_W) + 1;
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_ADDR  = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [c_CNT_W-1:0]       r_cnt;
    logic                     r_write;
    logic [ADDR_WIDTH-1:0]    r_addr_sh;
    logic [BURST_WIDTH-1:0]   r_burst_sh;
    logic [DATA_WIDTH-1:0]    r_wdata_sh;
    // Holds the first DATA_WIDTH-1 read bits; the final bit is merged
    // straight into rd_data on the last sampling edge.
    logic [DATA_WIDTH-2:0]    r_rx_sh;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic                     w_accept;
    logic                     w_timeout;
    logic                     w_err;

    assign w_accept = req_valid && req_ready;
    assign rd_data  = r_rd_data;
    assign err      = w_err;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = c_WAIT_W'(1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_err;
    logic                w_waiting;

    assign w_waiting = ((r_state == S_REQ)   && !slave_ready) ||
                       ((r_state == S_RDATA) && !slave_valid);
    assign w_timeout = w_waiting && (r_wait == c_WAIT_LAST);
    assign w_err     = r_err;

    // Any handshake bit (or leaving a wait state) clears the wait count.
    // The err pulse is issued from IDLE, so req_ready is held off for
    // that one cycle to keep the aborted transaction's err distinct.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_waiting && !w_timeout) begin
                r_wait <= r_wait + c_WAIT_ONE;
            end else begin
                r_wait <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        master_valid = 1'b0;
        master_ready = 1'b0;
        tx_address   = 1'b0;
        tx_burst     = 1'b0;
        tx_data      = 1'b0;
        done         = 1'b0;
        rd_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = !w_err;
                if (req_valid && !w_err) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (slave_ready) begin
                    w_state_next = S_ADDR;
                end else if (w_timeout) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ADDR: begin
                master_valid = 1'b1;
                tx_address   = r_addr_sh[0];
                tx_burst     = r_burst_sh[0];
                if (r_cnt == c_ADDR_LAST) begin
                    w_state_next = r_write ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                master_valid = 1'b1;
                tx_data      = r_wdata_sh[0];
                if (r_cnt == c_DATA_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_RDATA: begin
                master_ready = 1'b1;
                if (w_timeout) begin
                    w_state_next = S_IDLE;
                end else if (slave_valid && (r_cnt == c_DATA_LAST)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                rd_valid     = !r_write;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign read_en  = (r_state != S_IDLE) && !r_write;
    assign write_en = (r_state != S_IDLE) &&  r_write;

    // Datapath: bit counter and shift registers. Shifting right exposes
    // the next LSB-first bit at position 0; the burst register zero-fills,
    // so it naturally drives 0 once BURST_WIDTH bits have gone out.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_addr_sh  <= '0;
            r_burst_sh <= '0;
            r_wdata_sh <= '0;
            r_rx_sh    <= '0;
            r_rd_data  <= '0;
        end else begin
            if (r_state != w_state_next) begin
                r_cnt <= '0;
            end else if ((r_state == S_ADDR) || (r_state == S_WDATA) ||
                         ((r_state == S_RDATA) && slave_valid)) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write    <= req_write;
                        r_addr_sh  <= req_addr;
                        r_burst_sh <= req_burst;
                        r_wdata_sh <= req_wdata;
                        r_rx_sh    <= '0;
                    end
                end
                S_ADDR: begin
                    r_addr_sh  <= r_addr_sh >> 1;
                    r_burst_sh <= r_burst_sh >> 1;
                end
                S_WDATA: begin
                    r_wdata_sh <= r_wdata_sh >> 1;
                end
                S_RDATA: begin
                    if (slave_valid) begin
                        r_rx_sh <= {rx_data, r_rx_sh[DATA_WIDTH-2:1]};
                        if (r_cnt == c_DATA_LAST) begin
                            r_rd_data <= {rx_data, r_rx_sh};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_master_port.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_master_port
//  Purpose  : Directed self-checking bench for master_port. Cycle numbers
//             are counted from the request acceptance edge: the first cycle
//             after that edge (REQ) is cycle 1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_master_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic [11:0] req_burst;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic        err;
    logic        read_en;
    logic        write_en;
    logic        master_valid;
    logic        master_ready;
    logic        tx_address;
    logic        tx_burst;
    logic        tx_data;
    logic        slave_ready;
    logic        slave_valid;
    logic        rx_data;

    master_port #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (8),
        .BURST_WIDTH(12),
        .TIMEOUT    (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_burst   (req_burst),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .done        (done),
        .err         (err),
        .read_en     (read_en),
        .write_en    (write_en),
        .master_valid(master_valid),
        .master_ready(master_ready),
        .tx_address  (tx_address),
        .tx_burst    (tx_burst),
        .tx_data     (tx_data),
        .slave_ready (slave_ready),
        .slave_valid (slave_valid),
        .rx_data     (rx_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent transaction
    int          obs_done;
    int          obs_rdv;
    int          obs_rr_busy;
    int          obs_tx_bad;
    logic [11:0] obs_addr;
    logic [11:0] obs_burst;
    logic [7:0]  obs_wd;
    logic [7:0]  obs_rdata;

    localparam logic [10:0] IDLE_OUTS = 11'b100_0000_0000;

    function automatic logic [10:0] outs();
        return {req_ready, rd_valid, done, err, read_en, write_en,
                master_valid, master_ready, tx_address, tx_burst, tx_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction acting as the slave. Request fields are
    // inverted right after acceptance to show they are not re-sampled.
    task automatic do_txn(input logic wr, input logic [11:0] addr,
                          input logic [7:0] wd, input logic [11:0] bu,
                          input logic [7:0] rpat, input int rdy_delay,
                          input logic [31:0] gaps, input logic hold);
        int p;
        int nmv;
        int ri;
        int bi;
        req_valid   = 1'b1;
        req_write   = wr;
        req_addr    = addr;
        req_wdata   = wd;
        req_burst   = bu;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        obs_done    = -1;
        obs_rdv     = -1;
        obs_rr_busy = 0;
        obs_tx_bad  = 0;
        obs_addr    = '0;
        obs_burst   = '0;
        obs_wd      = '0;
        obs_rdata   = '0;
        tick();
        req_valid = hold;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wd;
        req_burst = ~bu;
        p   = 1;
        nmv = 0;
        ri  = 0;
        bi  = 0;
        while (p <= 300 && obs_done < 0) begin
            slave_ready = (p > rdy_delay);
            slave_valid = 1'b0;
            rx_data     = 1'b1;
            if (master_valid) begin
                if (nmv < 12) begin
                    obs_addr[nmv]  = tx_address;
                    obs_burst[nmv] = tx_burst;
                end else if (nmv < 20) begin
                    obs_wd[nmv-12] = tx_data;
                end
                nmv++;
            end else if (tx_address || tx_burst || tx_data) begin
                obs_tx_bad++;
            end
            if (master_ready) begin
                if (master_valid) obs_tx_bad++;
                if (!(ri < 32 && gaps[ri]) && bi < 8) begin
                    slave_valid = 1'b1;
                    rx_data     = rpat[bi];
                    bi++;
                end
                ri++;
            end
            if (req_ready) obs_rr_busy++;
            if (rd_valid) begin
                obs_rdv   = p;
                obs_rdata = rd_data;
            end
            if (done) obs_done = p;
            tick();
            p++;
        end
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        checks++;
        if (outs() !== IDLE_OUTS) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), IDLE_OUTS);
        end
        checks++;
        if (rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected 00", rd_data);
        end
        // Start a write and reset it while the address is shifting
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'hFFF;
        req_wdata = 8'hFF; req_burst = 12'hFFF;
        tick();
        req_valid   = 1'b0;
        slave_ready = 1'b1;
        repeat (4) tick();
        checks++;
        if (master_valid !== 1'b1 || write_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_addr_setup: master_valid=%b write_en=%b expected 1 1",
                     master_valid, write_en);
        end
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (outs() !== IDLE_OUTS) bad++;
        end
        reset = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid_addr_outputs: %0d bad cycles, last %b expected %b",
                     bad, outs(), IDLE_OUTS);
        end
        slave_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (done || write_en || read_en || master_valid) bad++;
            tick();
        end
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d active cycles after reset, expected 0", bad);
        end
    endtask

    task automatic test_write();
        do_txn(1'b1, 12'hADD, 8'hBD, 12'hAD5, 8'h00, 0, 32'h0, 1'b0);
        checks++;
        if (obs_addr !== 12'hADD) begin
            errors++;
            $display("FAIL write_addr_bits: got %h expected ADD", obs_addr);
        end
        checks++;
        if (obs_burst !== 12'hAD5) begin
            errors++;
            $display("FAIL write_burst_bits: got %h expected AD5", obs_burst);
        end
        checks++;
        if (obs_wd !== 8'hBD) begin
            errors++;
            $display("FAIL write_data_bits: got %h expected BD", obs_wd);
        end
        checks++;
        if (obs_done !== 22) begin
            errors++;
            $display("FAIL write_done_cycle: got %0d expected 22", obs_done);
        end
        checks++;
        if (obs_rdv !== -1 || obs_tx_bad !== 0) begin
            errors++;
            $display("FAIL write_side_effects: rd_valid cycle %0d (expected -1), idle tx bits %0d (expected 0)",
                     obs_rdv, obs_tx_bad);
        end
        checks++;
        if (done !== 1'b0 || req_ready !== 1'b1 || write_en !== 1'b0) begin
            errors++;
            $display("FAIL write_after_done: done=%b req_ready=%b write_en=%b expected 0 1 0",
                     done, req_ready, write_en);
        end
    endtask

    task automatic test_read();
        do_txn(1'b0, 12'h123, 8'h00, 12'h000, 8'hA5, 0, 32'h0, 1'b0);
        checks++;
        if (obs_addr !== 12'h123) begin
            errors++;
            $display("FAIL read_addr_bits: got %h expected 123", obs_addr);
        end
        checks++;
        if (obs_rdv !== 22 || obs_done !== 22) begin
            errors++;
            $display("FAIL read_done_cycle: rd_valid %0d done %0d expected 22 22", obs_rdv, obs_done);
        end
        checks++;
        if (obs_rdata !== 8'hA5) begin
            errors++;
            $display("FAIL read_data: got %h expected A5", obs_rdata);
        end
        checks++;
        if (rd_data !== 8'hA5 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: rd_data=%h rd_valid=%b expected A5 0", rd_data, rd_valid);
        end
    endtask

    task automatic test_stalls();
        // slave_ready low for 5 REQ cycles, slave_valid low on RDATA cycles 1, 3, 6
        do_txn(1'b0, 12'h0F0, 8'h00, 12'h000, 8'h3C, 5, 32'h0000_004A, 1'b0);
        checks++;
        if (obs_done !== 30 || obs_rdv !== 30) begin
            errors++;
            $display("FAIL stall_done_cycle: done %0d rd_valid %0d expected 30 30", obs_done, obs_rdv);
        end
        checks++;
        if (obs_rdata !== 8'h3C) begin
            errors++;
            $display("FAIL stall_read_data: got %h expected 3C", obs_rdata);
        end
        checks++;
        if (obs_addr !== 12'h0F0 || obs_tx_bad !== 0) begin
            errors++;
            $display("FAIL stall_addr_bits: got %h (bad idle %0d) expected 0F0 (0)", obs_addr, obs_tx_bad);
        end
    endtask

    task automatic test_back_to_back();
        // req_valid stays high: the next request must wait until after done
        do_txn(1'b1, 12'h5A3, 8'h6E, 12'h0F1, 8'h00, 0, 32'h0, 1'b1);
        checks++;
        if (obs_rr_busy !== 0 || obs_done !== 22) begin
            errors++;
            $display("FAIL b2b_busy: req_ready high %0d cycles, done %0d; expected 0, 22",
                     obs_rr_busy, obs_done);
        end
        checks++;
        if (obs_addr !== 12'h5A3 || obs_burst !== 12'h0F1 || obs_wd !== 8'h6E) begin
            errors++;
            $display("FAIL b2b_write_bits: addr %h burst %h data %h expected 5A3 0F1 6E",
                     obs_addr, obs_burst, obs_wd);
        end
        checks++;
        if (req_ready !== 1'b1 || rd_data !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_ready_after_done: req_ready=%b rd_data=%h expected 1 3C", req_ready, rd_data);
        end
        do_txn(1'b0, 12'hC0E, 8'h00, 12'h000, 8'h81, 0, 32'h0, 1'b0);
        checks++;
        if (obs_done !== 22 || obs_rdata !== 8'h81 || obs_addr !== 12'hC0E) begin
            errors++;
            $display("FAIL b2b_second_read: done %0d data %h addr %h expected 22 81 C0E",
                     obs_done, obs_rdata, obs_addr);
        end
    endtask

    task automatic test_timeout();
        int err_cycle;
        int err_count;
        int done_count;
        logic rd_en66;
        logic rr66;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h777;
        req_wdata = 8'h00; req_burst = 12'h000;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        tick();
        req_valid  = 1'b0;
        err_cycle  = -1;
        err_count  = 0;
        done_count = 0;
        rd_en66    = 1'bx;
        rr66       = 1'bx;
        for (int p = 1; p <= 80; p++) begin
            if (err) begin
                err_count++;
                if (err_cycle < 0) err_cycle = p;
            end
            if (done || rd_valid) done_count++;
            if (p == 66) begin
                rd_en66 = read_en;
                rr66    = req_ready;
            end
            tick();
        end
`ifdef MASTER_PORT_TIMEOUT_EN
        checks++;
        if (err_cycle !== 65 || err_count !== 1) begin
            errors++;
            $display("FAIL timeout_err: first err cycle %0d, %0d pulses; expected 65, 1", err_cycle, err_count);
        end
        checks++;
        if (rd_en66 !== 1'b0 || rr66 !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: cycle 66 read_en=%b req_ready=%b expected 0 1", rd_en66, rr66);
        end
`else
        checks++;
        if (err_count !== 0 || read_en !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout_wait: err pulses %0d read_en=%b req_ready=%b expected 0 1 0",
                     err_count, read_en, req_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
`endif
        checks++;
        if (done_count !== 0) begin
            errors++;
            $display("FAIL timeout_no_done: %0d done/rd_valid cycles expected 0", done_count);
        end
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_burst   = '0;
        slave_ready = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        test_reset();
        test_write();
        test_read();
        test_stalls();
        test_back_to_back();
        test_timeout();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
